// File: rtl/sad_pkg.sv
// Shared widths and FSM encoding for the motion-estimation SAD search.
package sad_pkg;
  localparam int DEF_EDGE_LEN            = 8;
  localparam int DEF_LOG_EDGE_LEN        = 3;
  localparam int DEF_BIT_DEPTH           = 8;
  localparam int DEF_PIXELS_IN_BATCH     = 16;
  localparam int DEF_LOG_PIXELS_IN_BATCH = 4;
  localparam int DEF_NUM_BATCHES         = 4;
  localparam int DEF_LOG_NUM_BATCHES     = 2;

  localparam int ROW_SAD_W = DEF_LOG_EDGE_LEN + DEF_BIT_DEPTH;
  localparam int BLK_SAD_W = 2 * DEF_LOG_EDGE_LEN + DEF_BIT_DEPTH;
  localparam int IDX_W     = DEF_LOG_NUM_BATCHES + DEF_LOG_PIXELS_IN_BATCH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/me_sad_search_if.sv
// Control, reference-stream and result signals of the SAD search engine.
interface me_sad_search_if;
  import sad_pkg::*;

  logic                                                       start;
  logic [DEF_EDGE_LEN*DEF_EDGE_LEN*DEF_BIT_DEPTH-1:0]         current_input_complete;
  logic                                                       ref_valid;
  logic                                                       ref_ready;
  logic [DEF_EDGE_LEN*DEF_PIXELS_IN_BATCH*DEF_BIT_DEPTH-1:0]  reference_input_column;
  logic [DEF_PIXELS_IN_BATCH*BLK_SAD_W-1:0]                   batch_sad;
  logic                                                       batch_valid;
  logic [BLK_SAD_W-1:0]                                       best_sad;
  logic [IDX_W-1:0]                                           best_index;
  logic                                                       done;
  logic                                                       busy;

  modport master (
    output start, current_input_complete, ref_valid, reference_input_column,
    input  ref_ready, batch_sad, batch_valid, best_sad, best_index, done, busy
  );

  modport slave (
    input  start, current_input_complete, ref_valid, reference_input_column,
    output ref_ready, batch_sad, batch_valid, best_sad, best_index, done, busy
  );
endinterface

// File: rtl/sad_row.sv
// Sum of absolute differences across one pixel row of a single candidate.
module sad_row
  import sad_pkg::*;
(
  input  logic [DEF_EDGE_LEN*DEF_BIT_DEPTH-1:0] cur_row,
  input  logic [DEF_EDGE_LEN*DEF_BIT_DEPTH-1:0] ref_row,
  output logic [ROW_SAD_W-1:0]                  row_sad
);

  function automatic logic [DEF_BIT_DEPTH-1:0] abs_diff(
    input logic [DEF_BIT_DEPTH-1:0] a,
    input logic [DEF_BIT_DEPTH-1:0] b
  );
    logic signed [DEF_BIT_DEPTH:0] d;
    logic signed [DEF_BIT_DEPTH:0] n;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    n = -d;
    abs_diff = d[DEF_BIT_DEPTH] ? n[DEF_BIT_DEPTH-1:0] : d[DEF_BIT_DEPTH-1:0];
  endfunction

  // Row width leaves log2(EDGE_LEN) headroom, so the sum cannot overflow
  always_comb begin
    row_sad = '0;
    for (int c = 0; c < DEF_EDGE_LEN; c++) begin
      row_sad = row_sad + ROW_SAD_W'(abs_diff(cur_row[c*DEF_BIT_DEPTH +: DEF_BIT_DEPTH],
                                               ref_row[c*DEF_BIT_DEPTH +: DEF_BIT_DEPTH]));
    end
  end

endmodule

// File: rtl/me_sad_search.sv
// Block-matching SAD search: streams candidate rows, accumulates per-candidate SADs, tracks best match.
module me_sad_search
  import sad_pkg::*;
#(
  parameter int EDGE_LEN            = DEF_EDGE_LEN,
  parameter int LOG_EDGE_LEN        = DEF_LOG_EDGE_LEN,
  parameter int BIT_DEPTH           = DEF_BIT_DEPTH,
  parameter int PIXELS_IN_BATCH     = DEF_PIXELS_IN_BATCH,
  parameter int LOG_PIXELS_IN_BATCH = DEF_LOG_PIXELS_IN_BATCH,
  parameter int NUM_BATCHES         = DEF_NUM_BATCHES,
  parameter int LOG_NUM_BATCHES     = DEF_LOG_NUM_BATCHES
) (
  input  logic                  clk,
  input  logic                  rst,
  me_sad_search_if.slave        bus
);

  localparam int ROW_BITS = EDGE_LEN * BIT_DEPTH;
  localparam logic [LOG_EDGE_LEN-1:0]    LAST_ROW   = LOG_EDGE_LEN'(EDGE_LEN - 1);
  localparam logic [LOG_NUM_BATCHES-1:0] LAST_BATCH = LOG_NUM_BATCHES'(NUM_BATCHES - 1);

  state_t                              state;
  logic [LOG_EDGE_LEN-1:0]             row_cnt;
  logic [LOG_NUM_BATCHES-1:0]          batch_cnt;
  logic [EDGE_LEN*EDGE_LEN*BIT_DEPTH-1:0] cur_blk;
  logic                                accept;
  logic                                stage3_go;

  logic [ROW_BITS-1:0]                 cur_row;
  logic [ROW_SAD_W-1:0]                row_sad_c  [PIXELS_IN_BATCH];

  logic [ROW_SAD_W-1:0]                row_sad_p1 [PIXELS_IN_BATCH];
  logic                                vld_p1, first_p1, last_p1;
  logic [LOG_NUM_BATCHES-1:0]          batch_p1;

  logic [BLK_SAD_W-1:0]                acc_p2     [PIXELS_IN_BATCH];
  logic                                vld_p2, last_p2;
  logic [LOG_NUM_BATCHES-1:0]          batch_p2;

  logic [BLK_SAD_W-1:0]                batch_sad_p3 [PIXELS_IN_BATCH];
  logic [LOG_NUM_BATCHES-1:0]          batch_p3;

  logic [BLK_SAD_W-1:0]                min_sad;
  logic [LOG_PIXELS_IN_BATCH-1:0]      min_idx;

  assign accept    = bus.ref_valid && bus.ref_ready;
  assign stage3_go = bus.batch_valid && (batch_p3 == LAST_BATCH);
  assign cur_row   = cur_blk[row_cnt*ROW_BITS +: ROW_BITS];

  // Control FSM; ref_ready/busy/done are registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      row_cnt       <= '0;
      batch_cnt     <= '0;
      cur_blk       <= '0;
      bus.ref_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cur_blk       <= bus.current_input_complete;
            row_cnt       <= '0;
            batch_cnt     <= '0;
            state         <= RUN;
            bus.ref_ready <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt   <= '0;
              batch_cnt <= batch_cnt + 1'b1;
              if (batch_cnt == LAST_BATCH) begin
                state         <= DRAIN;
                bus.ref_ready <= 1'b0;
              end
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (stage3_go) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < PIXELS_IN_BATCH; k++) begin : g_row
    sad_row u_sad_row (
      .cur_row (cur_row),
      .ref_row (bus.reference_input_column[k*ROW_BITS +: ROW_BITS]),
      .row_sad (row_sad_c[k])
    );
    assign bus.batch_sad[k*BLK_SAD_W +: BLK_SAD_W] = batch_sad_p3[k];
  end

  // Stage 1: capture row SADs of the accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      batch_p1 <= '0;
      for (int k = 0; k < PIXELS_IN_BATCH; k++) row_sad_p1[k] <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        first_p1 <= (row_cnt == '0);
        last_p1  <= (row_cnt == LAST_ROW);
        batch_p1 <= batch_cnt;
        for (int k = 0; k < PIXELS_IN_BATCH; k++) row_sad_p1[k] <= row_sad_c[k];
      end
    end
  end

  // Stage 2: per-candidate block accumulation, restarting on row 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2   <= 1'b0;
      last_p2  <= 1'b0;
      batch_p2 <= '0;
      for (int k = 0; k < PIXELS_IN_BATCH; k++) acc_p2[k] <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        last_p2  <= last_p1;
        batch_p2 <= batch_p1;
        for (int k = 0; k < PIXELS_IN_BATCH; k++) begin
          acc_p2[k] <= first_p1 ? BLK_SAD_W'(row_sad_p1[k])
                                : acc_p2[k] + BLK_SAD_W'(row_sad_p1[k]);
        end
      end
    end
  end

  // Batch result publish: one-cycle batch_valid with the finished block SADs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.batch_valid <= 1'b0;
      batch_p3        <= '0;
      for (int k = 0; k < PIXELS_IN_BATCH; k++) batch_sad_p3[k] <= '0;
    end else begin
      bus.batch_valid <= vld_p2 && last_p2;
      if (vld_p2 && last_p2) begin
        batch_p3 <= batch_p2;
        for (int k = 0; k < PIXELS_IN_BATCH; k++) batch_sad_p3[k] <= acc_p2[k];
      end
    end
  end

  // Pairwise min tree; the right (higher-index) side wins only when strictly smaller
  always_comb begin
    logic [BLK_SAD_W-1:0]           s  [PIXELS_IN_BATCH];
    logic [LOG_PIXELS_IN_BATCH-1:0] ix [PIXELS_IN_BATCH];
    for (int i = 0; i < PIXELS_IN_BATCH; i++) begin
      s[i]  = batch_sad_p3[i];
      ix[i] = LOG_PIXELS_IN_BATCH'(i);
    end
    for (int lvl = 0; lvl < LOG_PIXELS_IN_BATCH; lvl++) begin
      for (int i = 0; i < (PIXELS_IN_BATCH >> (lvl + 1)); i++) begin
        if (s[2*i+1] < s[2*i]) begin
          s[i]  = s[2*i+1];
          ix[i] = ix[2*i+1];
        end else begin
          s[i]  = s[2*i];
          ix[i] = ix[2*i];
        end
      end
    end
    min_sad = s[0];
    min_idx = ix[0];
  end

  // Stage 3: fold the batch minimum into the running best
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.best_sad   <= '0;
      bus.best_index <= '0;
    end else if (state == IDLE && bus.start) begin
      bus.best_sad   <= '0;
      bus.best_index <= '0;
    end else if (bus.batch_valid && (batch_p3 == '0 || min_sad < bus.best_sad)) begin
      bus.best_sad   <= min_sad;
      bus.best_index <= {batch_p3, min_idx};
    end
  end

endmodule

// File: tb/tb_me_sad_search.sv
// Scoreboard bench for me_sad_search: directed searches with hand-derived SAD results.
module tb_me_sad_search;
  import sad_pkg::*;

  localparam int E     = DEF_EDGE_LEN;
  localparam int P     = DEF_PIXELS_IN_BATCH;
  localparam int BD    = DEF_BIT_DEPTH;
  localparam int NB    = DEF_NUM_BATCHES;
  localparam int CUR_W = E * E * BD;
  localparam int REF_W = E * P * BD;
  localparam int BS_W  = P * BLK_SAD_W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  me_sad_search_if bus ();

  me_sad_search dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_acc = 0;
  int done_seen = 0;
  logic done_prev = 1'b0;

  typedef struct {
    logic [BLK_SAD_W-1:0] sad;
    logic [IDX_W-1:0]     idx;
  } best_t;

  logic [BS_W-1:0] exp_batch_q[$];
  best_t           exp_best_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_vec(input string name, input logic [BS_W-1:0] act, input logic [BS_W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [CUR_W-1:0] cur_block(input int mode);
    logic [CUR_W-1:0] v;
    v = '0;
    if (mode == 1)
      for (int i = 0; i < E*E; i++) v[i*BD +: BD] = 8'(10 + i);
    return v;
  endfunction

  function automatic logic [REF_W-1:0] ref_column(input int mode, input int b, input int r);
    logic [REF_W-1:0] v;
    v = '0;
    for (int k = 0; k < P; k++)
      for (int c = 0; c < E; c++)
        case (mode)
          0:       v[(k*E+c)*BD +: BD] = 8'd1;
          1:       v[(k*E+c)*BD +: BD] = 8'(10 + r*E + c + ((b == 2 && k == 5) ? 0 : 3));
          default: v[(k*E+c)*BD +: BD] = 8'd255;
        endcase
    return v;
  endfunction

  // Hand-derived: 64 pixels x |diff| per candidate
  function automatic logic [BS_W-1:0] exp_batch(input int mode, input int b);
    logic [BS_W-1:0] v;
    v = '0;
    for (int k = 0; k < P; k++)
      case (mode)
        0:       v[k*BLK_SAD_W +: BLK_SAD_W] = 14'd64;
        1:       v[k*BLK_SAD_W +: BLK_SAD_W] = (b == 2 && k == 5) ? 14'd0 : 14'd192;
        default: v[k*BLK_SAD_W +: BLK_SAD_W] = 14'd16320;
      endcase
    return v;
  endfunction

  function automatic best_t exp_best(input int mode);
    best_t b;
    case (mode)
      0:       begin b.sad = 14'd64;    b.idx = 6'd0;  end
      1:       begin b.sad = 14'd0;     b.idx = 6'd37; end
      default: begin b.sad = 14'd16320; b.idx = 6'd0;  end
    endcase
    return b;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (rst) begin
      if (bus.batch_valid) begin
        if (exp_batch_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_batch_valid: got batch_valid=1 expected no batch pending");
        end else begin
          check_vec("batch_sad", bus.batch_sad, exp_batch_q.pop_front());
        end
      end
      if (bus.done) begin
        done_seen++;
        if (exp_best_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done=1 expected no search pending");
        end else begin
          best_t b;
          b = exp_best_q.pop_front();
          check("best_sad", bus.best_sad, b.sad);
          check("best_index", bus.best_index, b.idx);
          check("done_latency", cyc - last_acc, 3);
        end
        if (done_prev) check("done_width", 2, 1);
      end
    end
    done_prev = bus.done;
  end

  task automatic run_search(input int mode, input bit gap, input int abort_after, input bit glitch);
    int  beat;
    int  tries;
    bit  tog;
    bit  v;
    beat  = 0;
    tries = 0;
    tog   = 1'b1;
    if (abort_after < 0) begin
      for (int b = 0; b < NB; b++) exp_batch_q.push_back(exp_batch(mode, b));
      exp_best_q.push_back(exp_best(mode));
    end else begin
      exp_batch_q.push_back(exp_batch(mode, 0));
    end
    @(negedge clk);
    bus.current_input_complete = cur_block(mode);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_in_run", bus.busy, 1);
    check("ready_in_run", bus.ref_ready, 1);
    while (beat < E*NB && tries < 400) begin
      tries++;
      if (abort_after >= 0 && beat == abort_after) break;
      v   = gap ? tog : 1'b1;
      tog = ~tog;
      bus.ref_valid = v;
      bus.reference_input_column = v ? ref_column(mode, beat / E, beat % E) : '1;
      if (glitch && beat == 12) begin
        bus.start = 1'b1;
        bus.current_input_complete = '0;
      end else begin
        bus.start = 1'b0;
      end
      if (v && bus.ref_ready) begin
        last_acc = cyc + 1;
        beat++;
      end
      @(negedge clk);
    end
    bus.ref_valid = 1'b0;
    bus.start     = 1'b0;
    if (abort_after < 0 && beat < E*NB) begin
      checks++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", beat, E*NB);
    end
    if (abort_after >= 0) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_ready", bus.ref_ready, 0);
      check("abort_best", bus.best_sad, 0);
      @(negedge clk);
      rst = 1'b1;
    end
  endtask

  task automatic wait_done(input int mode, input bit start_in_done);
    int    n;
    best_t b;
    n = 0;
    b = exp_best(mode);
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      return;
    end
    if (start_in_done) begin
      bus.start = 1'b1;
      bus.current_input_complete = '0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_busy_after_done", bus.busy, 0);
    check("idle_ready_after_done", bus.ref_ready, 0);
    repeat (3) @(negedge clk);
    check("hold_best_sad", bus.best_sad, b.sad);
    check("hold_best_index", bus.best_index, b.idx);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ref_valid = 1'b0;
    bus.current_input_complete = '0;
    bus.reference_input_column = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ref_ready", bus.ref_ready, 0);
    check("rst_batch_valid", bus.batch_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check_vec("rst_batch_sad", bus.batch_sad, '0);
    check("rst_best_sad", bus.best_sad, 0);
    check("rst_best_index", bus.best_index, 0);
    rst = 1'b1;
    @(negedge clk);

    run_search(0, 1'b0, -1, 1'b0);  wait_done(0, 1'b0);
    run_search(1, 1'b0, -1, 1'b0);  wait_done(1, 1'b0);
    run_search(2, 1'b0, -1, 1'b0);  wait_done(2, 1'b0);
    run_search(1, 1'b1, -1, 1'b0);  wait_done(1, 1'b0);
    run_search(0, 1'b0, 10, 1'b0);
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_seen, 4);
    run_search(0, 1'b0, -1, 1'b0);  wait_done(0, 1'b0);
    run_search(1, 1'b0, -1, 1'b1);  wait_done(1, 1'b1);
    repeat (4) @(negedge clk);

    check("done_count", done_seen, 6);
    check("batch_queue_drained", exp_batch_q.size(), 0);
    check("best_queue_drained", exp_best_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
